collision_searcher: RTL

Brute-force SHA-1 search engine that sits directly downstream of the message collector inside the collision custom instruction. It takes the accumulated 512-bit message template, a 32-bit target and a starting counter. It substitutes successive counter values into the low word of the block and runs one SHA-1 compression per candidate. It stops when the first digest word H0 equals the target. Several instances run in parallel, each scanning its own counter range.

---
 rtl/collision_pkg.sv | 35 +++
 rtl/sha1_round.sv | 52 +++++
 rtl/collision_searcher.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared constants and types for the SHA-1 collision search engine.
// Used by the message collector, the searcher and the instruction wrapper.
package collision_pkg;

  localparam int MSG_W = 512;

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [6:0] LAST_ROUND = 7'd79;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUND,
    ST_CHECK,
    ST_FOUND,
    ST_EXHAUSTED
  } state_e;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: f/K picked from the round index.
// Shared by any SHA-1 datapath in the instruction.
module sha1_round
  import collision_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] w,
  input  logic [6:0]  t,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n,
  output logic [31:0] e_n
);

  logic [31:0] f;
  logic [31:0] k;

  always_comb begin
    f = b ^ c ^ d;
    k = K3;
    unique case (1'b1)
      (t < 7'd20): begin
        f = (b & c) | (~b & d);
        k = K0;
      end
      (t >= 7'd20 && t < 7'd40): begin
        f = b ^ c ^ d;
        k = K1;
      end
      (t >= 7'd40 && t < 7'd60): begin
        f = (b & c) | (b & d) | (c & d);
        k = K2;
      end
      default: begin
        f = b ^ c ^ d;
        k = K3;
      end
    endcase
  end

  assign a_n = rotl(a, 5) + f + e + k + w;
  assign b_n = a;
  assign c_n = rotl(b, 30);
  assign d_n = c;
  assign e_n = d;

endmodule

// File: rtl/collision_searcher.sv
// Brute-force SHA-1 search: one round per cycle, one candidate per 81 cycles,
// stops when H0 of the candidate block equals the target.
module collision_searcher
  import collision_pkg::*;
#(
  parameter logic [31:0] SEARCH_LENGTH = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      target,
  input  logic [MSG_W-1:0] message,
  input  logic [31:0]      counter,
  output logic [31:0]      digests_computed,
  output logic             done,
  output logic [31:0]      result,
  output logic             exhausted
);

  state_e state_q, state_d;

  logic [6:0]  t_q, t_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [31:0] d_q, d_d;
  logic [31:0] e_q, e_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];

  logic [479:0] msg_q, msg_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  cand_q, cand_d;
  logic [31:0]  rem_q, rem_d;
  logic [31:0]  dig_q, dig_d;
  logic [31:0]  result_q, result_d;
  logic         done_q, done_d;
  logic         exh_q, exh_d;

  logic [31:0]  ra, rb, rc, rd, re;
  logic [31:0]  w_new;
  logic [31:0]  h0;
  logic [479:0] msg_src;
  logic         reload;

  logic unused_low_word;
  assign unused_low_word = ^message[31:0];

  sha1_round u_round (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .d   (d_q),
    .e   (e_q),
    .w   (w_q[0]),
    .t   (t_q),
    .a_n (ra),
    .b_n (rb),
    .c_n (rc),
    .d_n (rd),
    .e_n (re)
  );

  // Window holds W[t..t+15]; the incoming word is W[t+16].
  assign w_new = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
  assign h0 = a_q + IV0;
  assign msg_src = start ? message[511:32] : msg_q;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    e_d      = e_q;
    w_d      = w_q;
    msg_d    = msg_q;
    target_d = target_q;
    cand_d   = cand_q;
    rem_d    = rem_q;
    dig_d    = dig_q;
    result_d = result_q;
    done_d   = done_q;
    exh_d    = exh_q;
    reload   = 1'b0;

    if (start) begin
      msg_d    = message[511:32];
      target_d = target;
      cand_d   = counter;
      rem_d    = SEARCH_LENGTH;
      dig_d    = '0;
      done_d   = 1'b0;
      exh_d    = 1'b0;
      reload   = 1'b1;
      state_d  = ST_ROUND;
    end else begin
      case (state_q)
        ST_ROUND: begin
          a_d = ra;
          b_d = rb;
          c_d = rc;
          d_d = rd;
          e_d = re;
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = w_new;
          t_d = t_q + 7'd1;
          if (t_q == LAST_ROUND) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          dig_d = dig_q + 32'd1;
          rem_d = rem_q - 32'd1;
          if (h0 == target_q) begin
            result_d = cand_q;
            done_d   = 1'b1;
            state_d  = ST_FOUND;
          end else if (rem_q == 32'd1) begin
            exh_d   = 1'b1;
            state_d = ST_EXHAUSTED;
          end else begin
            cand_d  = cand_q + 32'd1;
            reload  = 1'b1;
            state_d = ST_ROUND;
          end
        end
        default: ;
      endcase
    end

    if (reload) begin
      a_d = IV0;
      b_d = IV1;
      c_d = IV2;
      d_d = IV3;
      e_d = IV4;
      t_d = '0;
      for (int i = 0; i < 15; i++) w_d[i] = msg_src[479-32*i -: 32];
      w_d[15] = cand_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      e_q      <= '0;
      w_q      <= '{default: '0};
      msg_q    <= '0;
      target_q <= '0;
      cand_q   <= '0;
      rem_q    <= '0;
      dig_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      exh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      e_q      <= e_d;
      w_q      <= w_d;
      msg_q    <= msg_d;
      target_q <= target_d;
      cand_q   <= cand_d;
      rem_q    <= rem_d;
      dig_q    <= dig_d;
      result_q <= result_d;
      done_q   <= done_d;
      exh_q    <= exh_d;
    end
  end

  assign digests_computed = dig_q;
  assign done             = done_q;
  assign result           = result_q;
  assign exhausted        = exh_q;

endmodule
